// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/status bundle of the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ready;
  logic [ADDR_W-1:0] readregister1;
  logic [ADDR_W-1:0] readregister2;
  logic [DATA_W-1:0] Readdata1;
  logic [DATA_W-1:0] Readdata2;
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;

  modport master (
    input  ready, Readdata1, Readdata2,
    output readregister1, readregister2, we0, wa0, wd0, we1, wa1, wd1
  );

  modport slave (
    output ready, Readdata1, Readdata2,
    input  readregister1, readregister2, we0, wa0, wd0, we1, wa1, wd1
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2R/2W register file with clear sweep, zero register and bypass
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // A write to entry 0 is dropped when entry 0 is hard-wired to zero.
  logic wr0_ok, wr1_ok;
  assign wr0_ok = bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
  assign wr1_ok = bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));

  // Sweep sequencing: step the pointer while clearing, enter RUN after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_ADDR) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end
  end

  // State register; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Storage: zero one entry per cycle while clearing; port 1 written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= '0;
      end else begin
        if (wr0_ok) mem_q[bus.wa0] <= bus.wd0;
        if (wr1_ok) mem_q[bus.wa1] <= bus.wd1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              run,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    if (!run)                                   return '0;
    if ((ZERO_REG != 0) && (addr == '0))        return '0;
    if ((BYPASS != 0) && we1 && (wa1 == addr))  return wd1;
    if ((BYPASS != 0) && we0 && (wa0 == addr))  return wd0;
    return stored;
  endfunction

  // Combinational read ports with zero-register and write-forwarding priority.
  always_comb begin
    bus.Readdata1 = read_port(bus.readregister1, mem_q[bus.readregister1], state_q == RUN,
                              bus.we0, bus.wa0, bus.wd0, bus.we1, bus.wa1, bus.wd1);
    bus.Readdata2 = read_port(bus.readregister2, mem_q[bus.readregister2], state_q == RUN,
                              bus.we0, bus.wa0, bus.wd0, bus.we1, bus.wa1, bus.wd1);
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of two regfile_mp configurations
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus; the small instance takes the low address/data bits.
  logic        we0, we1;
  logic [4:0]  wa0, wa1, ra1, ra2;
  logic [31:0] wd0, wd1;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

  assign ifa.we0 = we0;  assign ifa.wa0 = wa0;  assign ifa.wd0 = wd0;
  assign ifa.we1 = we1;  assign ifa.wa1 = wa1;  assign ifa.wd1 = wd1;
  assign ifa.readregister1 = ra1;  assign ifa.readregister2 = ra2;
  assign ifb.we0 = we0;  assign ifb.wa0 = wa0[2:0];  assign ifb.wd0 = wd0[15:0];
  assign ifb.we1 = we1;  assign ifb.wa1 = wa1[2:0];  assign ifb.wd1 = wd1[15:0];
  assign ifb.readregister1 = ra1[2:0];  assign ifb.readregister2 = ra2[2:0];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges survived since reset release, plus the architectural contents.
  int          cnt_a = 0, cnt_b = 0;
  logic [31:0] mem_a [32];
  logic [15:0] mem_b [8];

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (cnt_a != 32)              return 32'h0;
    if (addr == 5'd0)             return 32'h0;
    if (we1 && wa1 == addr)       return wd1;
    if (we0 && wa0 == addr)       return wd0;
    return mem_a[addr];
  endfunction

  function automatic logic [15:0] exp_b(input logic [2:0] addr);
    if (cnt_b != 8) return 16'h0;
    return mem_b[addr];
  endfunction

  task automatic update_models();
    if (rst) cnt_a = 0;
    else if (cnt_a < 32) begin
      cnt_a++;
      if (cnt_a == 32) foreach (mem_a[i]) mem_a[i] = 32'h0;
    end else begin
      if (we0 && wa0 != 5'd0) mem_a[wa0] = wd0;
      if (we1 && wa1 != 5'd0) mem_a[wa1] = wd1;
    end
    if (rst) cnt_b = 0;
    else if (cnt_b < 8) begin
      cnt_b++;
      if (cnt_b == 8) foreach (mem_b[i]) mem_b[i] = 16'h0;
    end else begin
      if (we0) mem_b[wa0[2:0]] = wd0[15:0];
      if (we1) mem_b[wa1[2:0]] = wd1[15:0];
    end
  endtask

  // Inputs are set just after an edge; outputs are sampled mid-cycle, then the edge is taken.
  task automatic tick(input bit chk);
    #4;
    if (chk) begin
      check("a_ready", 32'(ifa.ready), 32'(cnt_a == 32));
      check("a_rd1", ifa.Readdata1, exp_a(ra1));
      check("a_rd2", ifa.Readdata2, exp_a(ra2));
      check("b_ready", 32'(ifb.ready), 32'(cnt_b == 8));
      check("b_rd1", 32'(ifb.Readdata1), 32'(exp_b(ra1[2:0])));
      check("b_rd2", 32'(ifb.Readdata2), 32'(exp_b(ra2[2:0])));
    end
    @(posedge clk);
    #1;
    update_models();
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic randomize_inputs();
    we0 = 1'($urandom);
    we1 = 1'($urandom);
    wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    ra1 = ($urandom_range(0, 1) != 0) ? wa0 : 5'($urandom);
    ra2 = ($urandom_range(0, 1) != 0) ? wa1 : 5'($urandom);
    wd0 = $urandom;
    wd1 = $urandom;
  endtask

  initial begin
    idle();
    ra1 = '0; ra2 = '0;
    rst = 1'b1;
    tick(0);
    tick(1);
    rst = 1'b0;

    // T1: sweep length and cleared contents
    repeat (31) tick(1);
    check("t1_ready_31", 32'(ifa.ready), 32'h0);
    tick(1);
    check("t1_ready_32", 32'(ifa.ready), 32'h1);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      tick(1);
    end

    // T2: same-cycle forwarding vs stored-value read
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
    #2;
    check("t2_bypass_a", ifa.Readdata1, 32'hDEADBEEF);
    check("t2_old_b", 32'(ifb.Readdata1), 32'h0);
    tick(1);
    idle();
    #2;
    check("t2_new_b", 32'(ifb.Readdata1), 32'h0000BEEF);
    tick(1);

    // T3: write collision, port 1 wins
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1111;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2222;
    ra1 = 5'd9; ra2 = 5'd9;
    tick(1);
    idle();
    #2;
    check("t3_collide_a", ifa.Readdata1, 32'h2222);
    check("t3_collide_b", 32'(ifb.Readdata2), 32'h2222);
    tick(1);

    // T4: zero register discards writes, also during the write cycle
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #2;
    check("t4_zero_rd1_same", ifa.Readdata1, 32'h0);
    check("t4_zero_rd2_same", ifa.Readdata2, 32'h0);
    tick(1);
    idle();
    #2;
    check("t4_zero_rd1_after", ifa.Readdata1, 32'h0);
    check("t4_plain_b", 32'(ifb.Readdata1), 32'h0000FFFF);
    tick(1);

    // T5: reset mid-sweep restarts clearing; writes during clear are ignored
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5;
    tick(1);
    idle();
    ra1 = 5'd7;
    #2;
    check("t5_written", ifa.Readdata1, 32'hA5A5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    repeat (3) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      we0 = 1'b1; wa0 = 5'd7; wd0 = $urandom;
      we1 = 1'($urandom); wa1 = 5'($urandom); wd1 = $urandom;
      ra1 = 5'd7;
      tick(1);
      check("t5_ready_low", 32'(ifa.ready), 32'h0);
    end
    idle();
    tick(1);
    check("t5_ready_high", 32'(ifa.ready), 32'h1);
    ra1 = 5'd7;
    #2;
    check("t5_entry7_cleared", ifa.Readdata1, 32'h0);
    tick(1);

    // T6: random dual-write / dual-read traffic with occasional resets
    for (int n = 0; n < 10000; n++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
